mem_stage: RTL
==============

# mem_stage

Memory-access stage of the 5-stage MIPS32 pipeline. It consumes the EX/MEM register outputs, drives a word-wide data-memory request/ready handshake, and holds the pipeline while the memory is slow. It also owns the MEM/WB register, which feeds write-back with the selected result, destination register and write enable.

## Interface
Parameters:
- TIMEOUT, 255: max WAIT cycles before bus error (watchdog build only); range 1..65535
- CNT_W, 16: watchdog counter width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- z_MEM  in  32  ALU result / memory byte address
- B_MEM  in  32  store data
- sel4_MEM  in  1  1 = write back load data, 0 = write back z_MEM
- mem_wr_MEM  in  1  store
- mem_rd_MEM  in  1  load
- reg_wr_MEM  in  1  register write enable
- rd_MEM  in  5  destination register
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word-aligned address
- dmem_wdata  out  32  store data
- dmem_rdata  in  32  load data, valid when dmem_ready=1
- dmem_ready  in  1  access completes this cycle
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
- align_err  out  1  one-cycle pulse, misaligned access dropped
- bus_err  out  1  one-cycle pulse, watchdog expired (0 without watchdog)
- wb_data_WB  out  32  write-back value
- rd_WB  out  5  write-back register
- reg_wr_WB  out  1  write-back enable

## Operation
- access = mem_rd_MEM | mem_wr_MEM. mem_wr_MEM wins when both are set; dmem_we = mem_wr_MEM.
- misaligned = access & (z_MEM[1:0] != 0).
- A misaligned access raises no dmem_req. align_err is high that cycle. MEM/WB loads a bubble. No stall.
- dmem_addr = {z_MEM[31:2], 2'b00}. dmem_wdata = B_MEM.
- FSM states:
  - IDLE: dmem_req = access & ~misaligned. If dmem_ready=1 the access completes with zero wait. Otherwise stall=1 and the FSM moves to WAIT.
  - WAIT: dmem_req=1 and stall=1. Address, data and we stay constant because EX/MEM is frozen by stall. When dmem_ready=1: stall=0, the access completes, the FSM returns to IDLE.
- dmem_ready is ignored when dmem_req=0.
- MEM/WB load, every cycle:
  - completing load with sel4_MEM=1: wb_data_WB ← dmem_rdata
  - any other completing or non-access instruction: wb_data_WB ← z_MEM
  - rd_WB ← rd_MEM, reg_wr_WB ← reg_wr_MEM
  - stall cycle, misaligned cycle or bus-error cycle: bubble (wb_data_WB=0, rd_WB=0, reg_wr_WB=0)
- Outputs reset to 0: dmem_req, dmem_we, stall, align_err, bus_err, wb_data_WB, rd_WB, reg_wr_WB. FSM resets to IDLE; the watchdog counter resets to 0. dmem_addr and dmem_wdata are combinational pass-throughs.

## Timing
- Zero-wait access: one cycle in MEM; the result is visible on the WB outputs after the next rising edge.
- N wait cycles: stall is high for N cycles, and the result appears one edge after the cycle in which dmem_ready is seen.
- stall, dmem_req and align_err are combinational from the state, the EX/MEM inputs and dmem_ready. This is a permitted same-cycle path from dmem_ready to stall.
- Reset asserted in WAIT: dmem_req and stall drop immediately, the FSM goes to IDLE, and the in-flight access is abandoned. The memory side must tolerate this.
- Back-to-back accesses: the next access issues in the cycle after completion, with no idle gap.

## Configuration
- MEM_TIMEOUT_EN defined:
  - The watchdog counts WAIT cycles; the counter clears on entry to WAIT.
  - When the count reaches TIMEOUT without dmem_ready, that cycle: bus_err=1, stall=0, dmem_req=0, MEM/WB loads a bubble, and the FSM returns to IDLE.
  - dmem_ready arriving in the same cycle as expiry wins: normal completion, no bus_err.
- MEM_TIMEOUT_EN undefined: no counter; WAIT persists until dmem_ready; bus_err is tied to 0.

## Test plan
- Zero-wait load: z_MEM=0x100, mem_rd=1, sel4=1, rd=5, reg_wr=1, dmem_ready=1, rdata=0xDEADBEEF → stall never high; next edge: wb_data_WB=0xDEADBEEF, rd_WB=5, reg_wr_WB=1.
- 3-wait store: z_MEM=0x204, B_MEM=0x12345678, ready after 3 cycles → stall high for exactly 3 cycles; dmem_we=1 and addr/wdata stable throughout; bubbles in WB during the stall, then reg_wr_WB=reg_wr_MEM.
- Misaligned load: z_MEM=0x102, mem_rd=1 → dmem_req=0, align_err one-cycle pulse, reg_wr_WB=0 after the edge, no stall.
- ALU pass-through: access=0, z_MEM=0x55, rd=7, reg_wr=1 → wb_data_WB=0x55, rd_WB=7, reg_wr_WB=1.
- Reset during WAIT (2 cycles into the wait) → stall and dmem_req drop immediately; all WB outputs are 0; the next access starts from IDLE.
- With MEM_TIMEOUT_EN and TIMEOUT=4, dmem_ready held at 0 → bus_err pulses on the 4th WAIT cycle, stall releases, a bubble is written, the FSM is back in IDLE.

Source files
------------

// File: rtl/mem_stage.sv
// MIPS32 memory-access stage: data-memory handshake, pipeline hold and MEM/WB register.
// Optional bus watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_stage #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] z_MEM,
    input  logic [31:0] B_MEM,
    input  logic        sel4_MEM,
    input  logic        mem_wr_MEM,
    input  logic        mem_rd_MEM,
    input  logic        reg_wr_MEM,
    input  logic [4:0]  rd_MEM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic        stall,
    output logic        align_err,
    output logic        bus_err,
    output logic [31:0] wb_data_WB,
    output logic [4:0]  rd_WB,
    output logic        reg_wr_WB
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    generate
        if (TIMEOUT < 1 || TIMEOUT > 65535 || CNT_W < 1 ||
            TIMEOUT > (1 << CNT_W)) begin : g_bad_cfg
            $error("mem_stage: TIMEOUT does not fit the watchdog counter");
        end
    endgenerate

    state_t      state_q, state_d;
    logic        access;
    logic        misaligned;
    logic        is_load;
    logic        req_c;
    logic        stall_c;
    logic        complete;
    logic        expire;

    logic [31:0] wb_data_q, wb_data_d;
    logic [4:0]  rd_wb_q, rd_wb_d;
    logic        reg_wr_wb_q, reg_wr_wb_d;

    assign access     = mem_rd_MEM | mem_wr_MEM;
    assign misaligned = access & (z_MEM[1:0] != 2'b00);
    assign is_load    = mem_rd_MEM & ~mem_wr_MEM;

`ifdef MEM_TIMEOUT_EN
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Ready in the expiry cycle takes priority over the timeout.
    assign expire = (state_q == S_WAIT) & ~dmem_ready & (cnt_q == LIMIT);

    always_comb begin
        cnt_d = '0;
        if (state_q == S_WAIT && state_d == S_WAIT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        req_c    = 1'b0;
        stall_c  = 1'b0;
        complete = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                req_c = access & ~misaligned;
                if (req_c) begin
                    if (dmem_ready) begin
                        complete = 1'b1;
                    end else begin
                        stall_c = 1'b1;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (dmem_ready) begin
                    req_c    = 1'b1;
                    complete = 1'b1;
                    state_d  = S_IDLE;
                end else if (expire) begin
                    state_d = S_IDLE;
                end else begin
                    req_c   = 1'b1;
                    stall_c = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wb_data_d   = '0;
        rd_wb_d     = '0;
        reg_wr_wb_d = 1'b0;
        if (!(stall_c || misaligned || expire)) begin
            wb_data_d   = (complete && is_load && sel4_MEM) ? dmem_rdata : z_MEM;
            rd_wb_d     = rd_MEM;
            reg_wr_wb_d = reg_wr_MEM;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wb_data_q   <= '0;
            rd_wb_q     <= '0;
            reg_wr_wb_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wb_data_q   <= wb_data_d;
            rd_wb_q     <= rd_wb_d;
            reg_wr_wb_q <= reg_wr_wb_d;
        end
    end

    // Handshake outputs are combinational, so reset must force them low directly.
    assign dmem_req   = req_c & ~reset;
    assign dmem_we    = mem_wr_MEM & ~reset;
    assign stall      = stall_c & ~reset;
    assign align_err  = misaligned & ~reset;
    assign bus_err    = expire & ~reset;
    assign dmem_addr  = {z_MEM[31:2], 2'b00};
    assign dmem_wdata = B_MEM;

    assign wb_data_WB = wb_data_q;
    assign rd_WB      = rd_wb_q;
    assign reg_wr_WB  = reg_wr_wb_q;

endmodule
